// File: rtl/axis_sim_pkg.sv
// Shared types and defaults for the AXI-Stream simulation sink and source models.
package axis_sim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } axis_state_t;

  localparam int         DEFAULT_STALL_LIMIT   = 1024;
  localparam logic [7:0] DEFAULT_READY_PATTERN = 8'hFF;

  // Beat record shared with the planned source model; data width is fixed here.
  localparam int AXIS_BEAT_DATA_W = 32;

  typedef struct packed {
    logic [AXIS_BEAT_DATA_W-1:0] data;
    logic                        last;
  } axis_beat_t;

  // Rotate an 8-bit backpressure mask right by one position.
  function automatic logic [7:0] rotate_right8(input logic [7:0] value);
    return {value[0], value[7:1]};
  endfunction

endpackage

// File: rtl/axis_stream_sink_monitor_hold.sv
// AXI-Stream hold-rule checker: once a beat is offered and refused, the
// source must keep offering that same beat on the next cycle.
module axis_hold_checker #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  output logic              err_protocol
);

  logic              stalled_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              violation;

  // A refused beat last cycle must reappear unchanged while checking is enabled.
  always_comb begin
    violation = enable && stalled_q &&
                (!valid || (data != data_q) || (last != last_q));
  end

  // Keep a copy of the offered beat and latch any violation until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stalled_q    <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      stalled_q <= enable && valid && !ready;
      data_q    <= data;
      last_q    <= last;
      if (violation) begin
        err_protocol <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_stream_sink_monitor.sv
// Simulation sink for an AXI-Stream output: drives a rotating backpressure
// pattern, checks framing and hold rules, counts traffic and flags starvation.
module axis_stream_sink_monitor
  import axis_sim_pkg::*;
#(
  parameter int         DATA_W        = 32,
  parameter int         PKT_LEN       = 16,
  parameter int         NUM_PKTS      = 4,
  parameter int         STALL_LIMIT   = DEFAULT_STALL_LIMIT,
  parameter int         CNT_W         = 32,
  parameter logic [7:0] READY_PATTERN = DEFAULT_READY_PATTERN
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_axis_TDATA,
  input  logic              s_axis_TVALID,
  input  logic              s_axis_TLAST,
  output logic              s_axis_TREADY,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [DATA_W-1:0] signature,
  output logic              err_protocol,
  output logic              err_tlast,
  output logic              starve_block,
  output logic              done
);

  localparam int BIP_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  axis_state_t        state;
  axis_state_t        state_next;
  logic [7:0]         pattern;
  logic               handshake;
  logic               expected_last;
  logic [CNT_W-1:0]   pkt_cnt_inc;
  logic [BIP_W-1:0]   beat_in_pkt;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_next;

  assign handshake     = (state == RECV) && s_axis_TVALID && s_axis_TREADY;
  assign expected_last = (beat_in_pkt == BIP_W'(PKT_LEN - 1));
  assign pkt_cnt_inc   = pkt_cnt + CNT_W'(1);

  // Next state: start opens the receive window, the final packet closes it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RECV;
      RECV: if (handshake && s_axis_TLAST && (pkt_cnt_inc == CNT_W'(NUM_PKTS)))
              state_next = DONE;
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus the rotating ready mask that sets TREADY for the next cycle.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= IDLE;
      pattern       <= READY_PATTERN;
      s_axis_TREADY <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
      if (state_next == RECV) begin
        s_axis_TREADY <= pattern[0];
        pattern       <= rotate_right8(pattern);
      end else begin
        s_axis_TREADY <= 1'b0;
      end
    end
  end

  // Beat and packet accounting, signature and TLAST framing on every handshake.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      beat_cnt    <= '0;
      pkt_cnt     <= '0;
      signature   <= '0;
      beat_in_pkt <= '0;
      err_tlast   <= 1'b0;
    end else if (handshake) begin
      beat_cnt  <= beat_cnt + CNT_W'(1);
      signature <= signature ^ s_axis_TDATA;
      if (s_axis_TLAST != expected_last) begin
        err_tlast <= 1'b1;
      end
      if (s_axis_TLAST || expected_last) begin
        beat_in_pkt <= '0;
      end else begin
        beat_in_pkt <= beat_in_pkt + BIP_W'(1);
      end
      if (s_axis_TLAST) begin
        pkt_cnt <= pkt_cnt_inc;
      end
    end
  end

  // Count consecutive idle receive cycles, saturating at the limit.
  always_comb begin
    stall_next = '0;
    if ((state == RECV) && !s_axis_TVALID) begin
      stall_next = (stall_cnt == STALL_W'(STALL_LIMIT)) ? stall_cnt
                                                       : stall_cnt + STALL_W'(1);
    end
  end

  // Starvation counter and its registered block flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stall_cnt    <= '0;
      starve_block <= 1'b0;
    end else begin
      stall_cnt    <= stall_next;
      starve_block <= (stall_next == STALL_W'(STALL_LIMIT));
    end
  end

  axis_hold_checker #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk         (ap_clk),
    .rst         (ap_rst),
    .enable      (state == RECV),
    .valid       (s_axis_TVALID),
    .ready       (s_axis_TREADY),
    .data        (s_axis_TDATA),
    .last        (s_axis_TLAST),
    .err_protocol(err_protocol)
  );

endmodule

// File: tb/tb_axis_stream_sink_monitor.sv
// Bench for axis_stream_sink_monitor: two instances (ready mask FF and AA)
// checked every cycle against a behavioural model, plus directed literals.
`timescale 1ns/1ps
module tb_axis_stream_sink_monitor;
  import axis_sim_pkg::*;

  localparam int DATA_W      = 32;
  localparam int PKT_LEN     = 16;
  localparam int NUM_PKTS    = 4;
  localparam int STALL_LIMIT = 8;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             rst;
  logic [1:0]             start;
  logic [1:0]             tvalid;
  logic [1:0]             tlast;
  logic [1:0][DATA_W-1:0] tdata;

  logic              tready_a, tready_b;
  logic [CNT_W-1:0]  beats_a, beats_b, pkts_a, pkts_b;
  logic [DATA_W-1:0] sig_a, sig_b;
  logic              errp_a, errp_b, errt_a, errt_b, starve_a, starve_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  axis_stream_sink_monitor #(
    .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .NUM_PKTS(NUM_PKTS),
    .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W), .READY_PATTERN(8'hFF)
  ) dut_a (
    .ap_clk(clk), .ap_rst(rst[0]), .start(start[0]),
    .s_axis_TDATA(tdata[0]), .s_axis_TVALID(tvalid[0]), .s_axis_TLAST(tlast[0]),
    .s_axis_TREADY(tready_a), .beat_cnt(beats_a), .pkt_cnt(pkts_a),
    .signature(sig_a), .err_protocol(errp_a), .err_tlast(errt_a),
    .starve_block(starve_a), .done(done_a)
  );

  axis_stream_sink_monitor #(
    .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .NUM_PKTS(NUM_PKTS),
    .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W), .READY_PATTERN(8'hAA)
  ) dut_b (
    .ap_clk(clk), .ap_rst(rst[1]), .start(start[1]),
    .s_axis_TDATA(tdata[1]), .s_axis_TVALID(tvalid[1]), .s_axis_TLAST(tlast[1]),
    .s_axis_TREADY(tready_b), .beat_cnt(beats_b), .pkt_cnt(pkts_b),
    .signature(sig_b), .err_protocol(errp_b), .err_tlast(errt_b),
    .starve_block(starve_b), .done(done_b)
  );

  // Behavioural model state, one slot per instance.
  axis_state_t       m_state [2];
  int                m_k [2];
  logic              m_tready [2];
  logic [CNT_W-1:0]  m_beats [2];
  logic [CNT_W-1:0]  m_pkts [2];
  logic [DATA_W-1:0] m_sig [2];
  int                m_bip [2];
  logic              m_errp [2];
  logic              m_errt [2];
  int                m_idle [2];
  logic              m_prev_stall [2];
  logic [DATA_W-1:0] m_pdata [2];
  logic              m_plast [2];
  logic              m_known [2] = '{1'b0, 1'b0};

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Advance the model for instance i by one clock edge using the sampled inputs.
  task automatic modelStep(input int i);
    logic [7:0] pat;
    logic       hs;
    logic       exp_last;
    pat = (i == 0) ? 8'hFF : 8'hAA;
    if (rst[i]) begin
      m_state[i] = IDLE; m_k[i] = 0; m_tready[i] = 1'b0;
      m_beats[i] = '0; m_pkts[i] = '0; m_sig[i] = '0; m_bip[i] = 0;
      m_errp[i] = 1'b0; m_errt[i] = 1'b0; m_idle[i] = 0;
      m_prev_stall[i] = 1'b0; m_pdata[i] = '0; m_plast[i] = 1'b0;
      m_known[i] = 1'b1;
      return;
    end
    if (!m_known[i]) return;
    case (m_state[i])
      IDLE: begin
        if (start[i]) begin
          m_state[i]  = RECV;
          m_tready[i] = pat[0];
          m_k[i]      = 1;
        end
      end
      RECV: begin
        if (m_prev_stall[i] &&
            (!tvalid[i] || tdata[i] != m_pdata[i] || tlast[i] != m_plast[i]))
          m_errp[i] = 1'b1;
        m_prev_stall[i] = tvalid[i] && !m_tready[i];
        m_pdata[i] = tdata[i];
        m_plast[i] = tlast[i];
        if (tvalid[i]) m_idle[i] = 0;
        else if (m_idle[i] < STALL_LIMIT) m_idle[i] = m_idle[i] + 1;
        hs = tvalid[i] && m_tready[i];
        if (hs) begin
          m_beats[i] = m_beats[i] + 1;
          m_sig[i]   = m_sig[i] ^ tdata[i];
          exp_last   = (m_bip[i] == PKT_LEN - 1);
          if (tlast[i] != exp_last) m_errt[i] = 1'b1;
          m_bip[i] = (tlast[i] || exp_last) ? 0 : m_bip[i] + 1;
          if (tlast[i]) m_pkts[i] = m_pkts[i] + 1;
        end
        if (hs && tlast[i] && m_pkts[i] == CNT_W'(NUM_PKTS)) begin
          m_state[i] = DONE; m_tready[i] = 1'b0;
          m_idle[i] = 0; m_prev_stall[i] = 1'b0;
        end else begin
          m_tready[i] = pat[m_k[i] % 8];
          m_k[i] = m_k[i] + 1;
        end
      end
      default: ;
    endcase
  endtask

  // Model advances on the same edge as the DUT.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) modelStep(i);
  end

  task automatic compareInst(input int i, input logic rdy, input logic [CNT_W-1:0] bc,
                             input logic [CNT_W-1:0] pc, input logic [DATA_W-1:0] sg,
                             input logic ep, input logic et, input logic sb, input logic dn);
    checkOutput($sformatf("tready[%0d]", i), rdy, m_tready[i]);
    checkOutput($sformatf("beat_cnt[%0d]", i), bc, m_beats[i]);
    checkOutput($sformatf("pkt_cnt[%0d]", i), pc, m_pkts[i]);
    checkOutput($sformatf("signature[%0d]", i), sg, m_sig[i]);
    checkOutput($sformatf("err_protocol[%0d]", i), ep, m_errp[i]);
    checkOutput($sformatf("err_tlast[%0d]", i), et, m_errt[i]);
    checkOutput($sformatf("starve_block[%0d]", i), sb, m_idle[i] == STALL_LIMIT);
    checkOutput($sformatf("done[%0d]", i), dn, m_state[i] == DONE);
  endtask

  // Every-cycle comparison, sampled away from the active edge.
  always @(negedge clk) begin
    if (m_known[0]) compareInst(0, tready_a, beats_a, pkts_a, sig_a, errp_a, errt_a, starve_a, done_a);
    if (m_known[1]) compareInst(1, tready_b, beats_b, pkts_b, sig_b, errp_b, errt_b, starve_b, done_b);
  end

  task automatic doReset(input int i);
    rst[i] = 1'b1; start[i] = 1'b0; tvalid[i] = 1'b0; tlast[i] = 1'b0; tdata[i] = '0;
    @(negedge clk);
    rst[i] = 1'b0;
  endtask

  task automatic doStart(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Compliant source: beat index within packet as data, held until accepted.
  task automatic applyStimulus(input int i, input int nbeats, input int plen, output int cycles);
    int j;
    j = 0;
    cycles = 0;
    while (j < nbeats && cycles < 2000) begin
      tvalid[i] = 1'b1;
      tdata[i]  = DATA_W'(j % plen);
      tlast[i]  = ((j % plen) == plen - 1);
      if ((i == 0) ? tready_a : tready_b) j++;
      cycles++;
      @(negedge clk);
    end
    checkOutput($sformatf("beats_delivered[%0d]", i), j, nbeats);
    tvalid[i] = 1'b0;
    tlast[i]  = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 2'b11; start = '0; tvalid = '0; tlast = '0; tdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 2'b00;

    // Reset state literals.
    checkOutput("reset_tready", tready_a, 0);
    checkOutput("reset_beats", beats_a, 0);
    checkOutput("reset_done", done_a, 0);

    // Full-rate run: 4 packets of 16, signature of repeated 0..15 is zero.
    doStart(0);
    applyStimulus(0, 64, 16, cyc);
    checkOutput("ff_cycles", cyc, 64);
    checkOutput("ff_beats", beats_a, 64);
    checkOutput("ff_pkts", pkts_a, 4);
    checkOutput("ff_sig", sig_a, 0);
    checkOutput("ff_done", done_a, 1);
    checkOutput("ff_errp", errp_a, 0);
    checkOutput("ff_errt", errt_a, 0);

    // Alternating backpressure: 64 beats take 128 receive cycles.
    doReset(1);
    doStart(1);
    checkOutput("aa_first_ready", tready_b, 0);
    applyStimulus(1, 64, 16, cyc);
    checkOutput("aa_cycles", cyc, 128);
    checkOutput("aa_beats", beats_b, 64);
    checkOutput("aa_errp", errp_b, 0);
    checkOutput("aa_done", done_b, 1);

    // Hold violation: refused beat is withdrawn on the next cycle.
    doReset(1);
    doStart(1);
    tvalid[1] = 1'b1; tdata[1] = 32'h7; tlast[1] = 1'b0;
    @(negedge clk);
    tvalid[1] = 1'b0;
    @(negedge clk);
    checkOutput("hold_errp", errp_b, 1);
    repeat (3) @(negedge clk);
    checkOutput("hold_errp_sticky", errp_b, 1);
    doReset(1);
    checkOutput("hold_errp_cleared", errp_b, 0);

    // Early TLAST on beat 10, then a correct packet.
    doReset(0);
    doStart(0);
    applyStimulus(0, 11, 11, cyc);
    checkOutput("tlast_err", errt_a, 1);
    checkOutput("tlast_pkts", pkts_a, 1);
    applyStimulus(0, 16, 16, cyc);
    checkOutput("tlast_pkts2", pkts_a, 2);
    checkOutput("tlast_beats2", beats_a, 27);

    // Starvation: 8 idle receive cycles raise the block flag.
    doReset(0);
    doStart(0);
    for (int c = 2; c <= 8; c++) @(negedge clk);
    checkOutput("starve_pre", starve_a, 0);
    @(negedge clk);
    checkOutput("starve_on", starve_a, 1);
    @(negedge clk);
    checkOutput("starve_sat", starve_a, 1);
    tvalid[0] = 1'b1; tdata[0] = '0; tlast[0] = 1'b0;
    @(negedge clk);
    tvalid[0] = 1'b0;
    checkOutput("starve_off", starve_a, 0);

    // Reset mid-packet at beat 5, then a clean full run.
    doReset(0);
    doStart(0);
    applyStimulus(0, 5, 16, cyc);
    tvalid[0] = 1'b1; tdata[0] = 32'd5;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0; tvalid[0] = 1'b0;
    checkOutput("midrst_beats", beats_a, 0);
    checkOutput("midrst_sig", sig_a, 0);
    checkOutput("midrst_tready", tready_a, 0);
    doStart(0);
    applyStimulus(0, 64, 16, cyc);
    checkOutput("rerun_beats", beats_a, 64);
    checkOutput("rerun_pkts", pkts_a, 4);
    checkOutput("rerun_errt", errt_a, 0);
    checkOutput("rerun_done", done_a, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_stream_sink_monitor.md
Name: axis_stream_sink_monitor

Overview:
- Receiver-side counterpart to the kernel deadlock monitors: terminates the DUT's AXI-Stream output (output_r) in simulation.
- Drives TREADY from a programmable backpressure pattern and checks AXIS protocol and TLAST framing.
- Counts beats and packets, accumulates an XOR signature of the received data, and raises a starvation block flag when the producer stops delivering.
- The block flag feeds the per-index deadlock monitors as an extra axis_block_sigs bit.

Parameters:
- DATA_W, 32: TDATA width in bits.
- PKT_LEN, 16: expected beats per packet (>=1).
- NUM_PKTS, 4: packets to accept before entering DONE.
- STALL_LIMIT, 1024: consecutive starved cycles before starve_block asserts (>=1).
- CNT_W, 32: width of the beat and packet counters.
- READY_PATTERN, 8'hFF: initial value of the 8-bit rotating TREADY mask.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; IDLE->RECV.
- s_axis_TDATA  in  DATA_W  stream data.
- s_axis_TVALID  in  1  producer valid.
- s_axis_TLAST  in  1  end of packet.
- s_axis_TREADY  out  1  sink ready.
- beat_cnt  out  CNT_W  total accepted beats.
- pkt_cnt  out  CNT_W  total accepted packets.
- signature  out  DATA_W  XOR of all accepted TDATA.
- err_protocol  out  1  sticky: source violated the hold rule.
- err_tlast  out  1  sticky: TLAST position mismatch.
- starve_block  out  1  producer starved the sink for STALL_LIMIT cycles.
- done  out  1  NUM_PKTS packets received.

Behaviour:
- Reset (ap_rst=1 at a clock edge, any state) gives:
  - state=IDLE, pattern=READY_PATTERN.
  - All counters, signature and sticky flags cleared; starve_block=0, done=0, TREADY=0.
  - Reset takes effect mid-packet too; the partial packet is discarded.
- Handshake: a beat is accepted at a rising edge where TVALID=1 and TREADY=1. All outputs are registered; counter updates are visible the cycle after the handshake.
- FSM:
  - IDLE: TREADY=0. start=1 -> RECV.
  - RECV: TREADY = pattern[0], registered. The pattern rotates right by 1 every RECV cycle, whether or not a handshake occurs. A handshake with TLAST=1 that makes pkt_cnt==NUM_PKTS -> DONE.
  - DONE: TREADY=0, done=1. Stays in DONE until ap_rst; start is ignored.
- Beat tracking:
  - beat_in_pkt: internal counter, 0..PKT_LEN-1.
  - On each handshake, beat_cnt+1 and signature ^= TDATA.
  - Expected TLAST = (beat_in_pkt==PKT_LEN-1). A mismatch sets err_tlast.
  - beat_in_pkt returns to 0 when TLAST=1 or when the expected end is reached (resync after an error); otherwise it increments.
  - pkt_cnt increments on each handshake with TLAST=1.
  - Counters wrap modulo 2^CNT_W.
- Hold rule: if the previous cycle had TVALID=1 and TREADY=0, the current cycle must have TVALID=1 with TDATA and TLAST equal to their registered copies; otherwise err_protocol is set. The check applies only in RECV.
- Starvation:
  - stall_cnt counts RECV cycles with TVALID=0. It clears on any TVALID=1 cycle and on leaving RECV, and saturates at STALL_LIMIT.
  - starve_block = (stall_cnt==STALL_LIMIT), registered. It deasserts the cycle after TVALID returns.
  - Backpressure-induced stalls (TVALID=1, TREADY=0) do not count; they are owned by the sink's own output monitoring.
- Simultaneous events:
  - Final TLAST handshake plus a hold violation in the same cycle: both the flag and the DONE transition occur.
  - start while in RECV: ignored.
  - TVALID outside RECV: ignored; no checks, no counting.

Decomposition:
- Shared package axis_sim_pkg holds:
  - state enum {IDLE, RECV, DONE};
  - default constants for STALL_LIMIT and READY_PATTERN;
  - the axis beat struct {data, last}, also reused by a future source model.
- One natural sub-module: axis_hold_checker (registered-copy compare plus err_protocol), reusable on any AXIS port.
- Pattern rotator, counters and FSM stay in the top level.

Test Plan:
- READY_PATTERN=8'hFF, source always valid, 4x16 beats of data=beat index -> 64 handshakes, pkt_cnt=4, beat_cnt=64, signature=0, done=1 on the cycle after the last beat, err flags 0.
- READY_PATTERN=8'hAA, source always valid -> TREADY alternates starting 0; 64 beats accepted in 128 RECV cycles; no err_protocol from a compliant source.
- Source drops TVALID during a TREADY=0 cycle -> err_protocol=1 the following cycle and remains 1 until ap_rst.
- TLAST asserted on beat 10 of packet 0 (PKT_LEN=16) -> err_tlast=1, pkt_cnt=1, beat_in_pkt resyncs to 0.
- STALL_LIMIT=8, source idles in RECV for 8 cycles -> starve_block=1 at cycle 8; TVALID=1 -> starve_block=0 the next cycle.
- ap_rst asserted mid-packet at beat 5 -> all counts 0, state IDLE, TREADY=0; a subsequent start plus a full run passes cleanly.
